// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit command initiator: op codes, FSM states
// and the golden model used when LOGIC_UNIT_SEQ_CHECK_EN is defined.
package logic_unit_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Widest operand the golden model handles; callers truncate to their width.
  localparam int GOLD_W = 64;

  function automatic logic [GOLD_W-1:0] lu_golden(input logic [GOLD_W-1:0] a,
                                                  input logic [GOLD_W-1:0] b,
                                                  input logic [1:0]        op);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      default: return ~a;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Command / logic-unit / response bundle for logic_unit_seq.
// slave is the initiator block itself; master is its environment.
interface logic_unit_seq_if #(
  parameter int data_size    = 8,
  parameter int op_code_size = 2
);
  logic                    cmd_valid_in;
  logic                    cmd_ready_out;
  logic [data_size-1:0]    cmd_a_in;
  logic [data_size-1:0]    cmd_b_in;
  logic [op_code_size-1:0] cmd_op_in;
  logic [data_size-1:0]    lu_a_out;
  logic [data_size-1:0]    lu_b_out;
  logic [op_code_size-1:0] lu_op_out;
  logic [data_size-1:0]    lu_result_in;
  logic                    rsp_valid_out;
  logic                    rsp_ready_in;
  logic [data_size-1:0]    rsp_data_out;
  logic [op_code_size-1:0] rsp_op_out;
  logic                    err_out;

  modport slave (
    input  cmd_valid_in, cmd_a_in, cmd_b_in, cmd_op_in, lu_result_in, rsp_ready_in,
    output cmd_ready_out, lu_a_out, lu_b_out, lu_op_out,
           rsp_valid_out, rsp_data_out, rsp_op_out, err_out
  );

  modport master (
    output cmd_valid_in, cmd_a_in, cmd_b_in, cmd_op_in, lu_result_in, rsp_ready_in,
    input  cmd_ready_out, lu_a_out, lu_b_out, lu_op_out,
           rsp_valid_out, rsp_data_out, rsp_op_out, err_out
  );

endinterface

// File: rtl/logic_unit_seq_fifo.sv
// Synchronous command FIFO; depth must be a power of two so the pointers wrap
// by natural overflow.
module logic_unit_seq_fifo #(
  parameter int width = 18,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(depth));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset: clearing the pointers discards every entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Registered, flow-controlled initiator for the combinational logic unit.
// Optional result self-check: define LOGIC_UNIT_SEQ_CHECK_EN to enable err_out.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int data_size    = 8,
  parameter int op_code_size = 2,
  parameter int depth        = 4
) (
  input logic              clk,
  input logic              rst,
  logic_unit_seq_if.slave  bus
);
  localparam int CW = 2*data_size + op_code_size;

  state_t                  state, state_nxt;
  logic                    push, pop, capture, release_rsp;
  logic                    full, empty;
  logic [CW-1:0]           wdata, rdata;
  logic [data_size-1:0]    lu_a, lu_b, rsp_data;
  logic [op_code_size-1:0] lu_op, rsp_op;
  logic                    rsp_valid, err;

  // Ready is gated by rst so nothing is accepted during the reset cycle.
  assign bus.cmd_ready_out = !full && !rst;
  assign push              = bus.cmd_valid_in && bus.cmd_ready_out;
  assign wdata             = {bus.cmd_a_in, bus.cmd_b_in, bus.cmd_op_in};

  logic_unit_seq_fifo #(
    .width (CW),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        capture   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid && bus.rsp_ready_in) begin
          release_rsp = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Logic-unit inputs keep the last command once it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_a      <= '0;
      lu_b      <= '0;
      lu_op     <= '0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (pop) {lu_a, lu_b, lu_op} <= rdata;
      if (capture) begin
        rsp_data  <= bus.lu_result_in;
        rsp_op    <= lu_op;
        rsp_valid <= 1'b1;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_UNIT_SEQ_CHECK_EN
  logic [data_size-1:0] expect_res;

  assign expect_res = data_size'(lu_golden(GOLD_W'(lu_a), GOLD_W'(lu_b), 2'(lu_op)));

  always_ff @(posedge clk) begin
    if (rst)                                           err <= 1'b0;
    else if (capture && bus.lu_result_in != expect_res) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign bus.lu_a_out      = lu_a;
  assign bus.lu_b_out      = lu_b;
  assign bus.lu_op_out     = lu_op;
  assign bus.rsp_valid_out = rsp_valid;
  assign bus.rsp_data_out  = rsp_data;
  assign bus.rsp_op_out    = rsp_op;
  assign bus.err_out       = err;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: directed vectors, multi-cycle corner
// sequences and randomized traffic against a response-queue reference model.
module tb_logic_unit_seq;
  localparam int DW = 8, OW = 2, DEPTH = 4;
`ifdef LOGIC_UNIT_SEQ_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_seq_if #(.data_size(DW), .op_code_size(OW)) bus ();

  logic_unit_seq #(.data_size(DW), .op_code_size(OW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt = 0;
  logic corrupt = 1'b0;
  logic mon_en = 1'b1;

  typedef struct {
    logic [DW-1:0] data;
    logic [OW-1:0] op;
  } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt[8];

  // Behaviour of the external logic unit, from its op-code table.
  function automatic logic [DW-1:0] lu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a ^ b;
      2'd2:    return a & b;
      default: return ~a;
    endcase
  endfunction

  assign bus.lu_result_in = corrupt ? ~lu_ref(bus.lu_a_out, bus.lu_b_out, bus.lu_op_out)
                                    :  lu_ref(bus.lu_a_out, bus.lu_b_out, bus.lu_op_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_a_in     = a;
    bus.cmd_b_in     = b;
    bus.cmd_op_in    = op;
    tick();
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid_out) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: actual no response required response within 12 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    bus.rsp_ready_in = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (exp_q.size() == 0 && !bus.rsp_valid_out) break;
      tick();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted command queues its expected response; every
  // response handshake is compared in order. Held responses must stay stable.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [OW-1:0] prev_op;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("rsp_hold_valid", 32'(bus.rsp_valid_out), 32'd1);
        chk("rsp_hold_data", 32'(bus.rsp_data_out), 32'(prev_data));
        chk("rsp_hold_op", 32'(bus.rsp_op_out), 32'(prev_op));
      end
      if (bus.rsp_valid_out && bus.rsp_ready_in) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: actual data %0h required no response", bus.rsp_data_out);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(bus.rsp_data_out), 32'(e.data));
          chk("rsp_op", 32'(bus.rsp_op_out), 32'(e.op));
        end
      end
      if (bus.cmd_valid_in && bus.cmd_ready_out)
        exp_q.push_back('{lu_ref(bus.cmd_a_in, bus.cmd_b_in, bus.cmd_op_in), bus.cmd_op_in});
      prev_hold = bus.rsp_valid_out && !bus.rsp_ready_in;
      prev_data = bus.rsp_data_out;
      prev_op   = bus.rsp_op_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    int t_q[$];
    logic [DW-1:0] d_q[$];

    vt[0] = '{8'hA5, 8'h0F, 2'd0, 8'hAF};
    vt[1] = '{8'hA5, 8'h0F, 2'd1, 8'hAA};
    vt[2] = '{8'hA5, 8'h0F, 2'd2, 8'h05};
    vt[3] = '{8'hA5, 8'h0F, 2'd3, 8'h5A};
    vt[4] = '{8'hF0, 8'h3C, 2'd1, 8'hCC};
    vt[5] = '{8'h81, 8'h18, 2'd0, 8'h99};
    vt[6] = '{8'hF3, 8'h3F, 2'd2, 8'h33};
    vt[7] = '{8'h00, 8'h55, 2'd3, 8'hFF};

    bus.cmd_valid_in = 1'b0;
    bus.cmd_a_in     = '0;
    bus.cmd_b_in     = '0;
    bus.cmd_op_in    = '0;
    bus.rsp_ready_in = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready_out), 32'd0);
    chk("rst_lu_a", 32'(bus.lu_a_out), 32'd0);
    chk("rst_lu_b", 32'(bus.lu_b_out), 32'd0);
    chk("rst_lu_op", 32'(bus.lu_op_out), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data_out), 32'd0);
    chk("rst_rsp_op", 32'(bus.rsp_op_out), 32'd0);
    chk("rst_err", 32'(bus.err_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready_out), 32'd1);

    // Single-command latency
    send(8'hF0, 8'h3C, 2'd1);
    chk("lat_k0_valid", 32'(bus.rsp_valid_out), 32'd0);
    tick();
    chk("lat_k1_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("lat_k1_lu_a", 32'(bus.lu_a_out), 32'hF0);
    chk("lat_k1_lu_b", 32'(bus.lu_b_out), 32'h3C);
    chk("lat_k1_lu_op", 32'(bus.lu_op_out), 32'd1);
    tick();
    chk("lat_k2_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("lat_k2_data", 32'(bus.rsp_data_out), 32'hCC);
    chk("lat_k2_op", 32'(bus.rsp_op_out), 32'd1);
    tick();
    chk("lat_consumed", 32'(bus.rsp_valid_out), 32'd0);
    chk("lat_lu_a_retained", 32'(bus.lu_a_out), 32'hF0);

    // Table-driven single commands
    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].b, vt[i].op);
      wait_rsp("vec_timeout", ok);
      if (ok) begin
        chk("vec_data", 32'(bus.rsp_data_out), 32'(vt[i].exp));
        chk("vec_op", 32'(bus.rsp_op_out), 32'(vt[i].op));
      end
      tick();
    end

    // Back-to-back with ready high: responses every 2 cycles
    for (int c = 0; c < 20; c++) begin
      if (c < 4) begin
        bus.cmd_valid_in = 1'b1;
        bus.cmd_a_in     = 8'hA5;
        bus.cmd_b_in     = 8'h0F;
        bus.cmd_op_in    = OW'(c);
      end else begin
        bus.cmd_valid_in = 1'b0;
      end
      tick();
      if (bus.rsp_valid_out) begin
        t_q.push_back(c);
        d_q.push_back(bus.rsp_data_out);
      end
    end
    chk("b2b_count", 32'(t_q.size()), 32'd4);
    if (t_q.size() == 4) begin
      chk("b2b_first_at", 32'(t_q[0]), 32'd2);
      for (int j = 1; j < 4; j++) chk("b2b_spacing", 32'(t_q[j] - t_q[j-1]), 32'd2);
      chk("b2b_d0", 32'(d_q[0]), 32'hAF);
      chk("b2b_d1", 32'(d_q[1]), 32'hAA);
      chk("b2b_d2", 32'(d_q[2]), 32'h05);
      chk("b2b_d3", 32'(d_q[3]), 32'h5A);
    end

    // Response stall: 1 in RESP + DEPTH queued, then refusal
    bus.rsp_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 32'(bus.cmd_ready_out), 32'd1);
      send(DW'(8'h10 + i), DW'(8'h33 * i), OW'(i));
    end
    chk("stall_full", 32'(bus.cmd_ready_out), 32'd0);
    chk("stall_in_resp", 32'(bus.rsp_valid_out), 32'd1);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_a_in     = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_refuse", 32'(bus.cmd_ready_out), 32'd0);
    end
    bus.cmd_valid_in = 1'b0;
    base = rsp_cnt;
    bus.rsp_ready_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (rsp_cnt - base >= 5) break;
      tick();
    end
    tick();
    tick();
    tick();
    chk("stall_drain_count", 32'(rsp_cnt - base), 32'd5);
    chk("stall_drain_empty", 32'(exp_q.size()), 32'd0);

    // Push and pop at the same edge with depth-1 queued
    bus.rsp_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(8'h40 + i), 8'h0F, OW'(i));
    chk("pp_ready_before", 32'(bus.cmd_ready_out), 32'd1);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_a_in     = 8'h77;
    bus.cmd_op_in    = 2'd1;
    bus.rsp_ready_in = 1'b1;
    tick();
    bus.rsp_ready_in = 1'b0;
    chk("pp_ready_same_edge", 32'(bus.cmd_ready_out), 32'd1);
    bus.cmd_a_in = 8'h78;
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("pp_full_after", 32'(bus.cmd_ready_out), 32'd0);
    drain("pp_drain_empty");

    // Reset while in DRIVE with 3 queued
    bus.rsp_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(8'h90 + i), 8'hF0, OW'(i));
    bus.cmd_valid_in = 1'b1;
    bus.cmd_a_in     = 8'h9F;
    bus.rsp_ready_in = 1'b1;
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("mid_in_drive", 32'(bus.rsp_valid_out), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(bus.cmd_ready_out), 32'd0);
    chk("mid_rst_lu_a", 32'(bus.lu_a_out), 32'd0);
    chk("mid_rst_lu_b", 32'(bus.lu_b_out), 32'd0);
    chk("mid_rst_lu_op", 32'(bus.lu_op_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("mid_rst_data", 32'(bus.rsp_data_out), 32'd0);
    chk("mid_rst_op", 32'(bus.rsp_op_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", 32'(bus.cmd_ready_out), 32'd1);
    base = rsp_cnt;
    for (int c = 0; c < 10; c++) tick();
    chk("mid_no_rsp", 32'(rsp_cnt - base), 32'd0);
    chk("mid_no_valid", 32'(bus.rsp_valid_out), 32'd0);

    // Result self-check flag
    mon_en  = 1'b0;
    corrupt = 1'b1;
    send(8'h3C, 8'hC3, 2'd0);
    tick();
    chk("err_before_capture", 32'(bus.err_out), 32'd0);
    tick();
    chk("err_capture_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("err_rise", 32'(bus.err_out), 32'(ERR_EXP));
    corrupt = 1'b0;
    tick();
    mon_en = 1'b1;
    send(8'h5A, 8'hFF, 2'd2);
    wait_rsp("err_timeout", ok);
    chk("err_sticky", 32'(bus.err_out), 32'(ERR_EXP));
    for (int c = 0; c < 3; c++) tick();
    chk("err_sticky_later", 32'(bus.err_out), 32'(ERR_EXP));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(bus.err_out), 32'd0);

    // Randomized traffic against the response queue
    for (int c = 0; c < 400; c++) begin
      bus.cmd_valid_in = 1'($urandom_range(0, 1));
      bus.cmd_a_in     = DW'($urandom);
      bus.cmd_b_in     = DW'($urandom);
      bus.cmd_op_in    = OW'($urandom);
      bus.rsp_ready_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cmd_valid_in = 1'b0;
    drain("rand_drain_empty");
    chk("rand_err", 32'(bus.err_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
